// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM (FETCH/DECODE/EXECUTE/WRITEBACK) for the 4-bit-opcode CPU.
// Optional build macro CTRL_HALT_EN turns opcode F into HALT; otherwise F is a NOP.
module cpu_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       Eq,
  output logic       M1,
  output logic       M2,
  output logic       M3,
  output logic       M4,
  output logic       M5,
  output logic       M6,
  output logic       M7,
  output logic [1:0] state,
  output logic       pc_flag,
  output logic       change_address_flag,
  output logic       instruction_flag,
  output logic [3:0] ALU,
  output logic       Wr_en
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SEL_W = 7;

  typedef enum logic [1:0] {
    FETCH     = 2'b00,
    DECODE    = 2'b01,
    EXECUTE   = 2'b10,
    WRITEBACK = 2'b11
  } state_t;

  localparam logic [OP_W-1:0] OP_LW  = 4'hA;
  localparam logic [OP_W-1:0] OP_SW  = 4'hB;
  localparam logic [OP_W-1:0] OP_BEQ = 4'hC;
  localparam logic [OP_W-1:0] OP_BNE = 4'hD;
  localparam logic [OP_W-1:0] OP_JAL = 4'hE;

  state_t            st;
  state_t            st_nxt;
  logic              halt_c;
  logic [SEL_W-1:0]  sel_c;   // {M1,M2,M3,M4,M5,M6,M7}
  logic [OP_W-1:0]   alu_c;

`ifdef CTRL_HALT_EN
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;
  logic halted;

  // Halt latches at the first WRITEBACK of opcode F and holds until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) halted <= 1'b0;
    else        halted <= halt_c;
  end

  always_comb begin
    halt_c = halted | ((st == WRITEBACK) && (opcode == OP_HALT));
  end
`else
  always_comb begin
    halt_c = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= FETCH;
    else        st <= st_nxt;
  end

  // Next-state logic: fixed 4-cycle loop, parked in WRITEBACK when halted
  always_comb begin
    st_nxt = st;
    unique case (st)
      FETCH:     st_nxt = DECODE;
      DECODE:    st_nxt = EXECUTE;
      EXECUTE:   st_nxt = WRITEBACK;
      WRITEBACK: st_nxt = halt_c ? WRITEBACK : FETCH;
      default:   st_nxt = FETCH;
    endcase
  end

  // Opcode decode of datapath selects and ALU op; state-independent
  always_comb begin
    sel_c = '0;
    alu_c = '0;
    unique case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        sel_c = 7'b0001101;
        alu_c = opcode;
      end
      4'h7: sel_c = 7'b0000111;
      4'h8: begin
        sel_c = 7'b0000111;
        alu_c = 4'h2;
      end
      4'h9: begin
        sel_c = 7'b0000111;
        alu_c = 4'h3;
      end
      OP_BEQ:  sel_c = {1'b0, Eq, 5'b00000};
      OP_BNE:  sel_c = {1'b0, ~Eq, 5'b00000};
      OP_JAL:  sel_c = 7'b1010000;
      default: begin
        sel_c = '0;
        alu_c = '0;
      end
    endcase
  end

  // Output stage: everything forced low while reset is held
  always_comb begin
    {M1, M2, M3, M4, M5, M6, M7} = '0;
    ALU                 = '0;
    instruction_flag    = 1'b0;
    change_address_flag = 1'b0;
    Wr_en               = 1'b0;
    pc_flag             = 1'b0;
    state               = st;
    if (reset) begin
      {M1, M2, M3, M4, M5, M6, M7} = sel_c;
      ALU                 = alu_c;
      instruction_flag    = (st == FETCH);
      change_address_flag = (st == DECODE) && ((opcode == OP_LW) || (opcode == OP_SW));
      Wr_en               = (st == EXECUTE) && (opcode == OP_SW);
      pc_flag             = (st == WRITEBACK) && !halt_c;
    end else begin
      state = FETCH;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed-vector bench for cpu_control_unit; expected values are hand-computed per opcode.
module tb_cpu_control_unit;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       Eq;
  logic       M1, M2, M3, M4, M5, M6, M7;
  logic [1:0] state;
  logic       pc_flag;
  logic       change_address_flag;
  logic       instruction_flag;
  logic [3:0] ALU;
  logic       Wr_en;

  int n_vec  = 0;
  int n_miss = 0;

  cpu_control_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .opcode              (opcode),
    .Eq                  (Eq),
    .M1                  (M1),
    .M2                  (M2),
    .M3                  (M3),
    .M4                  (M4),
    .M5                  (M5),
    .M6                  (M6),
    .M7                  (M7),
    .state               (state),
    .pc_flag             (pc_flag),
    .change_address_flag (change_address_flag),
    .instruction_flag    (instruction_flag),
    .ALU                 (ALU),
    .Wr_en               (Wr_en)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // strobes packed as {instruction_flag, change_address_flag, Wr_en, pc_flag}
  task automatic chk_all(input string tag, input logic [1:0] st_e, input logic [6:0] sel_e,
                         input logic [3:0] alu_e, input logic [3:0] stb_e);
    chk($sformatf("%s state", tag), 32'(state), 32'(st_e));
    chk($sformatf("%s sel", tag), 32'({M1, M2, M3, M4, M5, M6, M7}), 32'(sel_e));
    chk($sformatf("%s alu", tag), 32'(ALU), 32'(alu_e));
    chk($sformatf("%s strobes", tag), 32'({instruction_flag, change_address_flag, Wr_en, pc_flag}),
        32'(stb_e));
  endtask

  // Entered just after a negedge while the DUT is in FETCH; leaves one negedge past WRITEBACK.
  task automatic run_instr(input logic [3:0] op, input logic eq, input logic [6:0] sel_e,
                           input logic [3:0] alu_e, input logic cadr, input logic wr,
                           input logic pcf);
    logic [3:0] stb;
    opcode = op;
    Eq     = eq;
    for (int s = 0; s < 4; s++) begin
      #1;
      stb = {s == 0, (s == 1) && cadr, (s == 2) && wr, (s == 3) && pcf};
      chk_all($sformatf("op%h eq%0d s%0d", op, eq, s), 2'(s), sel_e, alu_e, stb);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset  = 1'b0;
    opcode = 4'h0;
    Eq     = 1'b1;
    @(negedge clk);
    #1;
    chk_all("reset", 2'b00, 7'b0, 4'h0, 4'b0000);
    reset = 1'b1;

    // Reset asserted mid-EXECUTE of a store
    opcode = 4'hB;
    #1; chk_all("pre s0", 2'b00, 7'b0, 4'h0, 4'b1000);
    @(negedge clk); #1; chk_all("pre s1", 2'b01, 7'b0, 4'h0, 4'b0100);
    @(negedge clk); #1; chk_all("pre s2", 2'b10, 7'b0, 4'h0, 4'b0010);
    opcode = 4'h1;
    #2; reset = 1'b0;
    #1; chk_all("midrst", 2'b00, 7'b0, 4'h0, 4'b0000);
    @(negedge clk); #1; chk_all("midrst hold", 2'b00, 7'b0, 4'h0, 4'b0000);
    reset = 1'b1;

    // Arithmetic/logic register ops
    run_instr(4'h0, 1'b0, 7'b0001101, 4'h0, 1'b0, 1'b0, 1'b1);
    run_instr(4'h1, 1'b0, 7'b0001101, 4'h1, 1'b0, 1'b0, 1'b1);
    run_instr(4'h2, 1'b1, 7'b0001101, 4'h2, 1'b0, 1'b0, 1'b1);
    run_instr(4'h3, 1'b0, 7'b0001101, 4'h3, 1'b0, 1'b0, 1'b1);
    run_instr(4'h4, 1'b0, 7'b0001101, 4'h4, 1'b0, 1'b0, 1'b1);
    run_instr(4'h5, 1'b0, 7'b0001101, 4'h5, 1'b0, 1'b0, 1'b1);
    run_instr(4'h6, 1'b0, 7'b0001101, 4'h6, 1'b0, 1'b0, 1'b1);
    // Immediates
    run_instr(4'h7, 1'b0, 7'b0000111, 4'h0, 1'b0, 1'b0, 1'b1);
    run_instr(4'h8, 1'b0, 7'b0000111, 4'h2, 1'b0, 1'b0, 1'b1);
    run_instr(4'h9, 1'b1, 7'b0000111, 4'h3, 1'b0, 1'b0, 1'b1);
    // Memory
    run_instr(4'hA, 1'b0, 7'b0000000, 4'h0, 1'b1, 1'b0, 1'b1);
    run_instr(4'hB, 1'b0, 7'b0000000, 4'h0, 1'b1, 1'b1, 1'b1);
    // Branches and jump
    run_instr(4'hC, 1'b1, 7'b0100000, 4'h0, 1'b0, 1'b0, 1'b1);
    run_instr(4'hC, 1'b0, 7'b0000000, 4'h0, 1'b0, 1'b0, 1'b1);
    run_instr(4'hD, 1'b1, 7'b0000000, 4'h0, 1'b0, 1'b0, 1'b1);
    run_instr(4'hD, 1'b0, 7'b0100000, 4'h0, 1'b0, 1'b0, 1'b1);
    run_instr(4'hE, 1'b0, 7'b1010000, 4'h0, 1'b0, 1'b0, 1'b1);

    // M2 follows Eq combinationally inside WRITEBACK
    opcode = 4'hC; Eq = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1; chk("beq wb eq0 M2", 32'(M2), 32'd0);
    Eq = 1'b1;
    #1; chk("beq wb eq1 M2", 32'(M2), 32'd1);
    chk("beq wb state", 32'(state), 32'd3);
    opcode = 4'hD;
    #1; chk("bne wb eq1 M2", 32'(M2), 32'd0);
    @(negedge clk);

    // Opcode change mid-sequence leaves the state walk intact
    opcode = 4'h1;
    #1; chk_all("chg s0", 2'b00, 7'b0001101, 4'h1, 4'b1000);
    @(negedge clk); opcode = 4'hB;
    #1; chk_all("chg s1", 2'b01, 7'b0000000, 4'h0, 4'b0100);
    @(negedge clk); opcode = 4'h0;
    #1; chk_all("chg s2", 2'b10, 7'b0001101, 4'h0, 4'b0000);
    @(negedge clk); opcode = 4'hE;
    #1; chk_all("chg s3", 2'b11, 7'b1010000, 4'h0, 4'b0001);
    @(negedge clk);

`ifdef CTRL_HALT_EN
    run_instr(4'hF, 1'b0, 7'b0000000, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i == 6) opcode = 4'h0;
      #1; chk($sformatf("halt %0d state", i), 32'(state), 32'd3);
      chk($sformatf("halt %0d strobes", i),
          32'({instruction_flag, change_address_flag, Wr_en, pc_flag}), 32'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    #1; chk_all("halt rst", 2'b00, 7'b0, 4'h0, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    run_instr(4'h1, 1'b0, 7'b0001101, 4'h1, 1'b0, 1'b0, 1'b1);
`else
    run_instr(4'hF, 1'b0, 7'b0000000, 4'h0, 1'b0, 1'b0, 1'b1);
    run_instr(4'hF, 1'b1, 7'b0000000, 4'h0, 1'b0, 1'b0, 1'b1);
    run_instr(4'h0, 1'b0, 7'b0001101, 4'h0, 1'b0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle control FSM for the 32-bit, 4-bit-opcode CPU.
- Sequences every instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
- Drives the datapath mux/decoder selects M1..M7, the ALU operation code, the memory write enable, and the pc/instruction/address update strobes.
- Sits beside the register file, adder and ALU; the CPU top level feeds it `opcode` (instruction[31:28]) and `Eq` (Ra_rf == Rb_rf).

Parameters:
- None. Encodings are fixed: opcode 4 bits, ALU op 4 bits, state 2 bits.

Ports:
- clk  input  1  system clock (50 MHz)
- reset  input  1  asynchronous, active-low reset
- opcode  input  4  instruction[31:28] of the latched instruction
- Eq  input  1  1 when Ra_rf == Rb_rf
- M1  output  1  PC source: 0 = pc+mux2, 1 = Ra_rf
- M2  output  1  adder B input: 0 = constant 4, 1 = sign-extended imm
- M3  output  1  RF write data: 0 = mux7, 1 = pc
- M4  output  1  Rb route: 0 = memory address path, 1 = ALU B path
- M5  output  1  Ra route: 0 = memory data-in, 1 = ALU A
- M6  output  1  ALU B: 0 = Rb, 1 = sign-extended imm
- M7  output  1  mux7 source: 0 = memory, 1 = ALU
- state  output  2  current FSM state
- pc_flag  output  1  PC load strobe
- change_address_flag  output  1  memory-address load from Rb strobe
- instruction_flag  output  1  instruction fetch strobe
- ALU  output  4  ALU operation code
- Wr_en  output  1  data-memory write enable

Behaviour:
- **Reset.** Async, active-low: while reset=0, state=FETCH (2'b00) and every output is forced to 0.
- **FSM.** Fixed 4-cycle loop, no stalls: FETCH 00 -> DECODE 01 -> EXECUTE 10 -> WRITEBACK 11 -> FETCH. The state register is updated on posedge clk.
- **State-gated strobes** (all are 1-cycle pulses, 0 in every other state):
  - instruction_flag=1 in FETCH only.
  - change_address_flag=1 in DECODE only, and only when opcode is A or B.
  - Wr_en=1 in EXECUTE only, and only when opcode is B.
  - pc_flag=1 in WRITEBACK only, for every opcode.
- **Selects and ALU.** Combinational decode of `opcode` (and `Eq`), valid in every state outside reset. Any select not listed for an opcode below is 0.
- **Opcode map and ALU codes.**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL: ALU=opcode; M4=M5=M7=1.
  - 7 ADDI (ALU=0), 8 ANDI (ALU=2), 9 ORI (ALU=3): M5=M6=M7=1.
  - A LW: all selects 0; ALU=0 (Rb -> address, memory -> RF).
  - B SW: all selects 0 (Rb -> address, Ra -> memory data).
  - C BEQ: M2=Eq.
  - D BNE: M2=~Eq.
  - E JAL: M1=1, M3=1 (Rd <= pc, pc <= Ra).
  - F: see Optional Feature.
- **ALU field.** ALU=0 for every opcode not listed above.
- **Branches.** M2 tracks Eq combinationally; the value sampled at the WRITEBACK edge decides whether pc <= pc+imm or pc <= pc+4.
- **Mid-instruction reset.** Asserting reset in any state returns the FSM to FETCH; no partial strobe completes.
- **Opcode changes.** An opcode change mid-sequence (new instruction latched) only affects the combinational selects; the state sequence is unaffected.

Optional Feature:
- Macro: CTRL_HALT_EN.
- **Defined:** opcode F is HALT.
  - The FSM enters WRITEBACK and stays there with pc_flag=0 and all strobes 0 until reset.
  - `state` reads 11 while halted.
- **Undefined:** opcode F is NOP. It runs the normal 4-state loop with all selects 0 and ALU=0, so pc <= pc+4.

Test Plan:
- Reset low mid-EXECUTE, then release -> all outputs 0 during reset. Next edges: state 00 with instruction_flag=1, then 01, 10, 11 with pc_flag=1 only in 11.
- opcode=1 (SUB) held for 4 cycles -> ALU=1, M4=M5=M7=1, M6=0, Wr_en=0, change_address_flag=0 throughout.
- opcode=B (SW) -> change_address_flag=1 only in state 01; Wr_en=1 only in state 10; M4=M5=0.
- opcode=C: Eq=1 -> M2=1 at WRITEBACK; Eq=0 -> M2=0. opcode=D gives the inverse.
- opcode=E (JAL) -> M1=1, M3=1, ALU=0; pc_flag pulses once in state 11.
- opcode=F: with CTRL_HALT_EN, state sticks at 11 with pc_flag=0 for 10+ cycles until reset. Without it, normal 4-cycle loop with pc_flag=1 in 11.
